// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with registered status flags, sticky
// error flags and selectable registered or first-word-fall-through read.
module sync_fifo_param #(
  parameter int DW        = 140,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_w_enable,
  input  logic [DW-1:0]              data_to_fifo,
  input  logic                       fifo_r_enable,
  output logic [DW-1:0]              data_from_fifo,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       fifo_almost_full,
  output logic                       fifo_almost_empty,
  output logic                       fifo_overflow,
  output logic                       fifo_underflow,
  input  logic                       err_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic wr_acc;
  logic rd_acc;

  // Acceptance looks only at pre-edge flags, so full+both favours the read.
  assign wr_acc = fifo_w_enable & ~full_q;
  assign rd_acc = fifo_r_enable & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rdata_d  = mem_q[rd_ptr_q];
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == FULL_L);
    empty_d = (level_d == '0);
    af_d    = (level_d >= AF_L);
    ae_d    = (level_d <= AE_L);
    // A fresh event outranks a simultaneous clear.
    ovf_d = (ovf_q & ~err_clear) | (fifo_w_enable & full_q);
    unf_d = (unf_q & ~err_clear) | (fifo_r_enable & empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_to_fifo;
  end

  assign data_from_fifo    = (FWFT != 0) ? mem_q[rd_ptr_q] : rdata_q;
  assign fifo_full         = full_q;
  assign fifo_empty        = empty_q;
  assign fifo_level        = level_q;
  assign fifo_almost_full  = af_q;
  assign fifo_almost_empty = ae_q;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;

endmodule
